// File: rtl/mem_rw_ctrl_if.sv
// Request/response bus for mem_rw_ctrl. The controller takes the slave modport.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
interface mem_rw_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_exp;
  logic          read;
  logic          write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [15:0]   error_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_exp, rsp_ready,
    output req_ready, read, write, rsp_valid, rsp_rdata, rsp_err, error_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_exp, rsp_ready,
    input  req_ready, read, write, rsp_valid, rsp_rdata, rsp_err, error_count
  );
endinterface

// File: rtl/mem_rw_ctrl.sv
// Single-port register memory with a request/response controller (IDLE/WR/RD/RESP).
// Define MEM_RW_CTRL_RDCHK_EN to compare read data against req_exp and count mismatches.
module mem_rw_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_rw_ctrl_if.slave     bus,
  output logic [1:0]       dbg_state
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = bus.req_we ? WR : RD;
      WR:   state_d = IDLE;
      RD:   state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and handshake outputs are pure state decodes, so reset clears them at once.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.write     = (state_q == WR);
  assign bus.read      = (state_q == RD);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == WR) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_rdata_q <= '0;
    else if (state_q == RD)  rsp_rdata_q <= mem[addr_q];
  end

`ifdef MEM_RW_CTRL_RDCHK_EN
  logic [DW-1:0] exp_data_q;
  logic          rsp_err_q;
  logic [15:0]   err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              exp_data_q <= '0;
    else if (state_q == IDLE && bus.req_valid) exp_data_q <= bus.req_exp;
  end

  // The compare is registered alongside rsp_rdata so both hold steady through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rsp_err_q <= 1'b0;
    else if (state_q == RD) rsp_err_q <= (mem[addr_q] != exp_data_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (state_q == RESP && bus.rsp_ready && rsp_err_q && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign bus.rsp_err     = rsp_err_q;
  assign bus.error_count = err_cnt_q;
`else
  assign bus.rsp_err     = 1'b0;
  assign bus.error_count = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_rw_ctrl.sv
// Self-checking bench for mem_rw_ctrl: driver tasks, golden memory model and a response scoreboard.
// Error expectations follow MEM_RW_CTRL_RDCHK_EN when it is defined for the build.
module tb_mem_rw_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  mem_rw_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  mem_rw_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Scoreboard entry: {expected rsp_err, expected rsp_rdata}.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem [1 << AW];
  logic [15:0]   model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) check("rw_excl", 32'(bus.read & bus.write), 0);

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_read", 32'(bus.read), 0);
    check("rst_write", 32'(bus.write), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_err", 32'(bus.rsp_err), 0);
    check("rst_cnt", 32'(bus.error_count), 0);
    check("rst_state", 32'(dbg_state), 0);
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    model_cnt = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check(tag, 32'(bus.req_ready), 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready("wr_ready_timeout");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_exp   = DW'($urandom);
    @(negedge clk);
    check("wr_strobe", 32'(bus.write), 1);
    check("wr_no_read", 32'(bus.read), 0);
    check("wr_busy", 32'(bus.req_ready), 0);
    bus.req_valid = 1'b0;
    model_mem[a] = d;
    @(negedge clk);
    check("wr_strobe_end", 32'(bus.write), 0);
    check("wr_ready_again", 32'(bus.req_ready), 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold, input bit abort);
    logic          err;
    logic [DW:0]   item;
    wait_ready("rd_ready_timeout");
`ifdef MEM_RW_CTRL_RDCHK_EN
    err = (model_mem[a] != e);
`else
    err = 1'b0;
`endif
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = DW'($urandom);
    bus.req_exp   = e;
    exp_q.push_back({err, model_mem[a]});
    @(negedge clk);
    check("rd_strobe", 32'(bus.read), 1);
    check("rd_no_write", 32'(bus.write), 0);
    check("rd_no_rsp_yet", 32'(bus.rsp_valid), 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rd_rsp_valid_n2", 32'(bus.rsp_valid), 1);
    check("rd_strobe_end", 32'(bus.read), 0);
    if (abort) begin
      apply_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      check("hold_req_ready", 32'(bus.req_ready), 0);
      check("hold_rdata", 32'(bus.rsp_rdata), 32'(exp_q[0][DW-1:0]));
    end
    bus.req_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    item = exp_q.pop_front();
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(item[DW-1:0]));
    check("rsp_err", 32'(bus.rsp_err), 32'(item[DW]));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    if (item[DW] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    bus.rsp_ready = 1'b0;
    check("rsp_done", 32'(bus.rsp_valid), 0);
    check("idle_ready", 32'(bus.req_ready), 1);
    check("error_count", 32'(bus.error_count), 32'(model_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_exp   = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    apply_reset();

    do_write(4'd3, 8'hA5);
    do_read(4'd3, 8'hA5, 0, 1'b0);

    do_read(4'd7, 8'h00, 5, 1'b0);

    do_write(4'd1, 8'h11);
    do_read(4'd1, 8'h22, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      if (i % 2 == 0) do_write(a, DW'($urandom));
      else            do_read(a, model_mem[a], $urandom_range(0, 2), 1'b0);
    end

    do_write(4'd2, 8'h5A);
    do_read(4'd2, 8'h5A, 0, 1'b1);
    do_read(4'd2, 8'h00, 0, 1'b0);

`ifdef MEM_RW_CTRL_RDCHK_EN
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    model_cnt = 16'hFFFE;
`endif
    do_write(4'd5, 8'h3C);
    do_read(4'd5, 8'hC3, 0, 1'b0);
    do_read(4'd5, 8'h00, 1, 1'b0);
    do_read(4'd5, 8'h3C, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_rw_ctrl.md
MEM_RW_CTRL -- requirements
Module: mem_rw_ctrl

Interface
REQ-001 The block SHALL provide parameter: DW, 8, data width in bits.
REQ-002 The block SHALL provide parameter: AW, 4, address width; memory depth 2**AW words.
REQ-003 The block SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports: req_valid  input  1  request present.
REQ-006 The block SHALL have ports: req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 The block SHALL have ports: req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have ports: req_addr  input  AW  word address.
REQ-009 The block SHALL have ports: req_wdata  input  DW  write data.
REQ-010 The block SHALL have ports: req_exp  input  DW  expected read data (correct_data).
REQ-011 The block SHALL have ports: read  output  1  read strobe, one cycle per accepted read.
REQ-012 The block SHALL have ports: write  output  1  write strobe, one cycle per accepted write.
REQ-013 The block SHALL have ports: rsp_valid  output  1  read response present.
REQ-014 The block SHALL have ports: rsp_ready  input  1  consumer accepts response.
REQ-015 The block SHALL have ports: rsp_rdata  output  DW  read data.
REQ-016 The block SHALL have ports: rsp_err  output  1  read data differed from captured req_exp.
REQ-017 The block SHALL have ports: error_count  output  16  count of mismatched reads.

Function
REQ-018 The FSM SHALL have states IDLE, WR, RD, RESP; req_ready high only in IDLE.
REQ-019 In IDLE, when req_valid && req_ready, the block SHALL capture addr, wdata, exp and go to WR if req_we else RD.
REQ-020 In WR the block SHALL assert write for exactly one cycle, update mem[addr] at that cycle's end, and return to IDLE; writes produce no response.
REQ-021 In RD the block SHALL assert read for exactly one cycle, register mem[addr] into rsp_rdata, and go to RESP.
REQ-022 In RESP rsp_valid SHALL be high and rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE in the next cycle.
REQ-023 Latency: request accepted in cycle N -> strobe in N+1; read rsp_valid first high in N+2; next request acceptable at N+2 (write) or one cycle after response handshake (read).
REQ-024 read and write SHALL never be high in the same cycle.
REQ-025 A read SHALL return data of a write to the same address whose strobe occurred in any earlier cycle.
REQ-026 Address wrap: req_addr is used modulo 2**AW; no out-of-range case exists.
REQ-027 req_valid deasserting before acceptance SHALL cause no action; inputs outside IDLE are ignored.

Reset
REQ-028 On rst_n low, the block SHALL immediately set: FSM IDLE, read 0, write 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, error_count 0, all memory words 0.
REQ-029 Reset mid-operation SHALL abort any pending write strobe or response; aborted transactions are discarded.
REQ-030 After rst_n rises, req_ready SHALL be high on the first clock edge.

Configuration
REQ-031 Macro MEM_RW_CTRL_RDCHK_EN SHALL gate the read-data check.
REQ-032 With MEM_RW_CTRL_RDCHK_EN defined: rsp_err = (read data != captured req_exp), registered with rsp_rdata; error_count increments by 1 once per mismatched response at its handshake, saturating at 16'hFFFF.
REQ-033 Without MEM_RW_CTRL_RDCHK_EN: rsp_err tied 0, error_count tied 0, no compare or counter logic; req_exp unused.

Verification
REQ-034 Reset then write addr 3 data 8'hA5, then read addr 3 exp 8'hA5 -> write pulse 1 cycle, read pulse 1 cycle, rsp_rdata 8'hA5, rsp_err 0, rsp_valid at N+2.
REQ-035 Read addr 7 (never written) exp 8'h00 with rsp_ready held 0 for 5 cycles -> rsp_valid held 5+ cycles, rsp_rdata 8'h00 stable, req_ready 0 throughout.
REQ-036 Write addr 1 = 8'h11, read addr 1 exp 8'h22 (RDCHK_EN) -> rsp_err 1, error_count 1; without macro rsp_err 0, error_count 0.
REQ-037 Back-to-back req_valid alternating we=1/0 for 20 requests, random addr -> read&&write never both high, all reads match a golden model.
REQ-038 Assert rst_n low during RESP after write 8'h5A to addr 2 -> rsp_valid 0 immediately, error_count 0, subsequent read addr 2 returns 8'h00.
REQ-039 Force error_count to 16'hFFFF via mismatches (or preload in bench) then one more mismatch -> error_count stays 16'hFFFF.
